// File: rtl/mul_seq.sv
// Sequential 32x32 -> 64 shift-add multiplier, signed or unsigned, fixed 34-cycle latency.
// Operands are multiplied as magnitudes; the sign is applied once in FIXUP.
//
//   state | meaning
//   IDLE  | waiting for valid; c holds the last product
//   BUSY  | one shift-add iteration per edge, CYCLES edges
//   FIXUP | apply result sign, publish c, pulse done
module mul_seq #(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        is_signed,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] c
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [5:0] CNT_INIT = 6'(CYCLES);

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic        r_neg;
    logic [63:0] r_c;
    logic        r_done;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_addend;

    // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude.
    assign w_a_mag  = (is_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag  = (is_signed && b[31]) ? (~b + 32'd1) : b;
    assign w_addend = r_mplier[0] ? r_mcand : 64'd0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 6'd0;
            r_mcand  <= 64'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_neg    <= 1'b0;
            r_c      <= 64'd0;
            r_done   <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_mcand  <= {32'd0, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= is_signed & (a[31] ^ b[31]);
                        r_acc    <= 64'd0;
                        r_cnt    <= CNT_INIT;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc    <= r_acc + w_addend;
                    r_mcand  <= {r_mcand[62:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_cnt    <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    r_c     <= r_neg ? (~r_acc + 64'd1) : r_acc;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign c    = r_c;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter CYCLES, default 32, the number of shift-add iterations; only 32 is supported.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port valid  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with valid.
REQ-006 SHALL have port flush  input  1  synchronous abort of the operation in flight.
REQ-007 SHALL have port a  input  32  multiplicand; sampled with valid.
REQ-008 SHALL have port b  input  32  multiplier; sampled with valid.
REQ-009 SHALL have port busy  output  1  high in BUSY and FIXUP.
REQ-010 SHALL have port done  output  1  registered one-cycle completion pulse.
REQ-011 SHALL have port c  output  64  product {hi, lo}; hi in c[63:32], lo in c[31:0].

Function
REQ-012 SHALL implement states IDLE, BUSY and FIXUP, held in a register.
REQ-013 SHALL, in IDLE with valid=1 and flush=0, capture the operands and go to BUSY with iteration counter = 32.
REQ-014 SHALL capture operands as magnitudes: |a| and |b| when is_signed=1; raw a and b when is_signed=0.
REQ-015 SHALL register the result sign neg = is_signed & (a[31] ^ b[31]).
REQ-016 SHALL clear the 64-bit accumulator at capture.
REQ-017 SHALL, on each BUSY edge, add the 64-bit multiplicand to the accumulator if the multiplier LSB is 1, then shift the multiplicand left 1, shift the multiplier right 1 and decrement the counter.
REQ-018 SHALL go from BUSY to FIXUP on the edge where the counter reaches 0 (exactly 32 BUSY edges).
REQ-019 SHALL, on the FIXUP edge, write c = neg ? (~acc + 1) mod 2^64 : acc, set done for the next cycle and return to IDLE.
REQ-020 SHALL have a fixed latency: valid accepted at edge E gives done=1 in the cycle following edge E+33; no data dependence.
REQ-021 SHALL hold done high for exactly one cycle and low otherwise.
REQ-022 SHALL hold c stable from the FIXUP edge until the next FIXUP edge; c is not disturbed by accept, BUSY or flush.
REQ-023 SHALL ignore valid, a, b and is_signed while busy=1.
REQ-024 SHALL accept a valid that arrives in the done cycle (state already IDLE), giving back-to-back operations every 34 cycles.
REQ-025 SHALL treat the magnitude of 0x80000000 as 2^31, which fits the 32-bit magnitude register unsigned.
REQ-026 SHALL, on flush=1 in any state, go to IDLE next edge with done=0 and c unchanged.
REQ-027 SHALL give flush priority over valid on the same edge, so no operation starts.
REQ-028 SHALL give a zero operand the full 34-cycle latency with c=0 (no early exit).
REQ-029 SHALL implement arithmetic modulo 2^64; the product always fits, so no overflow indication is provided.

Reset
REQ-030 SHALL, with resetn=0 at a rising edge, set state=IDLE, counter=0, accumulator=0, c=0, done=0, busy=0.
REQ-031 SHALL, on reset mid-operation, discard the operation with no done pulse.
REQ-032 SHALL give reset priority over flush and valid.
REQ-033 SHALL accept valid on the first edge after resetn returns high.

Verification
REQ-034 SHALL pass: unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> c=0xFFFFFFFE00000001, done exactly 34 edges after the accepting edge, busy high for 33 cycles.
REQ-035 SHALL pass: signed a=0xFFFFFFFD (-3), b=5 -> c=0xFFFFFFFFFFFFFFF1; then unsigned with the same operands -> c=0x00000004FFFFFFF1.
REQ-036 SHALL pass: signed a=0x80000000, b=0x80000000 -> c=0x4000000000000000; signed a=0x80000000, b=1 -> c=0xFFFFFFFF80000000.
REQ-037 SHALL pass: back-to-back, valid held high with 7x6 then 0x0 -> c=42 at the first done, c=0 at the second done, done pulses 34 cycles apart, no cycle with busy=0 between them except the done cycle.
REQ-038 SHALL pass: flush at BUSY cycle 10 of 3x3 (previous c=42) -> no done, c stays 42, busy=0 next cycle; resetn=0 at cycle 20 of another operation -> c=0, done never asserted.
REQ-039 SHALL pass: valid and flush high together in IDLE -> busy stays 0.
